apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, paddr / requester address width
- DATA_W, 32, pwdata / prdata / requester data width
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort (>=2)
REQ-002 The block SHALL have one clock and a synchronous, active-low reset. Ports, one per line: name, direction, width, meaning.
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  synchronous active-low reset
- req0, req1  in  1 each  level transfer request, requester 0 / 1
- write0, write1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  ADDR_W each  transfer address
- wdata0, wdata1  in  DATA_W each  write data
- done0, done1  out  1 each  one-cycle completion pulse to requester 0 / 1
- rdata  out  DATA_W  read data of the last completed transfer
- err  out  1  valid with done: 1 = transfer aborted on timeout
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready

Function
REQ-003 FSM states SHALL be IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-004 IDLE: psel=0, penable=0. On an edge where an eligible request exists, the block SHALL grant one requester, latch its write/addr/wdata into pwrite/paddr/pwdata, and go to SETUP.
REQ-005 Eligible: reqN=1 and doneN=0 in that cycle. The requester SHALL drop reqN in its done cycle; a request held through done is ignored for that cycle only.
REQ-006 Arbitration SHALL be round-robin: if only one requester is eligible, it is granted; if both are, the requester not granted last is granted. The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-007 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-008 ACCESS: psel=1, penable=1. paddr/pwdata/pwrite SHALL stay stable from SETUP until the transfer ends.
REQ-009 Completion: on an ACCESS edge with pready=1, the block SHALL go to IDLE, set doneN=1 for the granted requester for the next cycle only, and set err=0.
- Read: rdata <= prdata on that edge.
- Write: rdata is held unchanged.
REQ-010 Minimum transfer time SHALL be 3 cycles: IDLE (grant), SETUP, ACCESS with pready=1. Back-to-back grants SHALL be possible from the done cycle onward for the other requester.
REQ-011 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0. If pready is still 0 in the TIMEOUT-th ACCESS cycle, the block SHALL abort:
- go to IDLE;
- pulse doneN with err=1;
- set rdata <= 0.
REQ-012 If pready=1 in the TIMEOUT-th ACCESS cycle, the transfer SHALL complete normally (err=0).
REQ-013 err SHALL be held until the next done pulse. done0 and done1 SHALL never be 1 in the same cycle.
REQ-014 Requester inputs SHALL be ignored outside IDLE; changes to reqN/addrN/wdataN mid-transfer SHALL not affect the APB outputs.
REQ-015 pready SHALL be ignored in IDLE and SETUP.

Reset
REQ-016 With preset=0 at an edge, the block SHALL enter IDLE and set:
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- done0=0, done1=0, rdata=0, err=0;
- wait counter=0, last-grant=1.
REQ-017 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort the transfer with no done pulse. The first grant after reset release SHALL occur no earlier than the first edge with preset=1.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single write: req0, write0=1, addr0=0x04, wdata0=0xDEADBEEF, pready=1 → SETUP next cycle, ACCESS after, done0 on the 4th cycle, err=0, paddr=0x04, pwdata=0xDEADBEEF.
- Read with waits: req1 read of addr1=0x10, pready low for 3 ACCESS cycles, prdata=0x12345678 → done1 after 6 cycles, rdata=0x12345678.
- Tie and fairness: req0 and req1 held continuously, pready=1 → grants alternate 0,1,0,1; every transfer is 3 cycles; done0 and done1 are never both high.
- Timeout: TIMEOUT=16, pready held 0 → abort after 16 ACCESS cycles, done0=1, err=1, rdata=0; a following normal transfer gives err=0.
- Reset mid-ACCESS: preset=0 in the 2nd ACCESS cycle → next cycle psel=0, penable=0, no done pulse; after release, a tie grants requester 0.
- Stability: addr0 and wdata0 changed during SETUP/ACCESS → paddr/pwdata keep their latched values until done.

Source files
------------

// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration and pready timeout.
// A timed-out transfer completes with err=1 and rdata cleared.
module apb_arb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              req0,
   input  logic              req1,
   input  logic              write0,
   input  logic              write1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic              psel_q, psel_d;
   logic              pen_q, pen_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic e0, e1, pick;

   // A requester still holding req in its own done cycle is not eligible.
   assign e0   = req0 & ~done0_q;
   assign e1   = req1 & ~done1_q;
   assign pick = (e0 & e1) ? ~last_q : e1;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      wait_d   = wait_q;
      psel_d   = psel_q;
      pen_d    = pen_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (e0 | e1) begin
               gnt_d    = pick;
               last_d   = pick;
               pwrite_d = pick ? write1 : write0;
               paddr_d  = pick ? addr1 : addr0;
               pwdata_d = pick ? wdata1 : wdata0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            pen_d   = 1'b1;
            wait_d  = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready || (wait_q == WLAST)) begin
               state_d = IDLE;
               psel_d  = 1'b0;
               pen_d   = 1'b0;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               err_d   = ~pready;
               if (!pready)
                  rdata_d = '0;
               else if (!pwrite_q)
                  rdata_d = prdata;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         wait_q   <= '0;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         wait_q   <= wait_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign psel    = psel_q;
   assign penable = pen_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata   = rdata_q;
   assign err     = err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: vector table plus scoreboard of expected
// transfers, checked on APB phases and on done pulses.
module tb_apb_arb_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          pclk = 1'b0;
   logic          preset = 1'b0;
   logic          req0 = 0, req1 = 0, write0 = 0, write1 = 0;
   logic [AW-1:0] addr0 = 0, addr1 = 0;
   logic [DW-1:0] wdata0 = 0, wdata1 = 0;
   logic          done0, done1, err, psel, penable, pwrite;
   logic [DW-1:0] rdata, pwdata;
   logic [AW-1:0] paddr;
   logic [DW-1:0] prdata = 0;
   logic          pready = 0;

   apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .pclk(pclk), .preset(preset),
      .req0(req0), .req1(req1),
      .write0(write0), .write1(write1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1),
      .rdata(rdata), .err(err),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic        who;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prd;
      int          waits;
   } vec_t;

   typedef struct {
      logic        who;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prd;
      logic        tmo;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_rdata = 0;
   logic        m_err = 0;
   bit          mon_on = 0;
   int          slv_waits = 0;
   logic [31:0] slv_prd = 0;
   int          acc_cnt = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Slave: pready high in idle/setup (must be ignored), then after
   // slv_waits low ACCESS cycles; prdata is junk while not ready.
   always @(posedge pclk) begin
      #1;
      if (psel && penable) begin
         pready = (acc_cnt == slv_waits);
         acc_cnt++;
      end else begin
         pready = 1'b1;
         acc_cnt = 0;
      end
      prdata = pready ? slv_prd : $urandom;
   end

   always @(negedge pclk) begin
      exp_t e;
      if (mon_on && preset) begin
         if (psel) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL apb_unexpected: got psel=1 want no transfer");
            end else begin
               chk("paddr", paddr, sb[0].addr);
               chk("pwrite", {31'b0, pwrite}, {31'b0, sb[0].wr});
               if (sb[0].wr)
                  chk("pwdata", pwdata, sb[0].wdata);
            end
         end
         if (done0 || done1) begin
            chk("done_excl", {31'b0, done0 & done1}, 32'd0);
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL done_unexpected: got done=1 want 0");
            end else begin
               e = sb.pop_front();
               m_err = e.tmo;
               m_rdata = e.tmo ? 32'd0 : (e.wr ? m_rdata : e.prd);
               chk("done_who", {31'b0, done1}, {31'b0, e.who});
               chk("err", {31'b0, err}, {31'b0, m_err});
               chk("rdata", rdata, m_rdata);
            end
         end else begin
            chk("err_hold", {31'b0, err}, {31'b0, m_err});
         end
      end
   end

   task automatic run_vec(vec_t v);
      exp_t e;
      int   edges;
      bit   got;
      e.who = v.who; e.wr = v.wr; e.addr = v.addr;
      e.wdata = v.wdata; e.prd = v.prd; e.tmo = (v.waits >= TMO);
      @(posedge pclk); #1;
      sb.push_back(e);
      slv_waits = v.waits;
      slv_prd = v.prd;
      if (!v.who) begin
         req0 = 1; write0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
      end else begin
         req1 = 1; write1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
      end
      edges = 0;
      got = 0;
      while (!got && edges < 100) begin
         @(posedge pclk); #1;
         edges++;
         got = v.who ? done1 : done0;
         if (psel && !got) begin
            if (!v.who) begin
               addr0 = $urandom; wdata0 = $urandom; write0 = ~write0;
            end else begin
               addr1 = $urandom; wdata1 = $urandom; write1 = ~write1;
            end
         end
      end
      if (!v.who) req0 = 0; else req1 = 0;
      chk("latency", 32'(edges), 32'(e.tmo ? 2 + TMO : 3 + v.waits));
   endtask

   task automatic tie_run(int n, logic first);
      exp_t e;
      int   edges, got, last_e, need0, need1, c0, c1;
      edges = 0; got = 0; last_e = 0; c0 = 0; c1 = 0;
      need0 = first ? n / 2 : (n + 1) / 2;
      need1 = n - need0;
      for (int i = 0; i < n; i++) begin
         e.who = first ^ ((i % 2) == 1);
         e.wr = 1'b1;
         e.addr = e.who ? 32'h24 : 32'h20;
         e.wdata = e.who ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
         e.prd = 0;
         e.tmo = 1'b0;
         sb.push_back(e);
      end
      slv_waits = 0;
      @(posedge pclk); #1;
      req0 = (need0 > 0); write0 = 1; addr0 = 32'h20; wdata0 = 32'hA0A0A0A0;
      req1 = (need1 > 0); write1 = 1; addr1 = 32'h24; wdata1 = 32'hB1B1B1B1;
      while (got < n && edges < 30 * n) begin
         @(posedge pclk); #1;
         edges++;
         if (done0 || done1) begin
            got++;
            chk("tie_gap", 32'(edges - last_e), 32'd3);
            last_e = edges;
            if (done0) begin c0++; if (c0 >= need0) req0 = 0; end
            if (done1) begin c1++; if (c1 >= need1) req1 = 0; end
         end
      end
      req0 = 0;
      req1 = 0;
      chk("tie_count", 32'(got), 32'(n));
   endtask

   initial begin
      vec_t vt[8];
      exp_t e;
      int   pc;

      vt[0] = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 0};
      vt[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h12345678, 3};
      vt[2] = '{1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1};
      vt[3] = '{1'b0, 1'b0, 32'h08, 32'h0, 32'h55AA55AA, 99};
      vt[4] = '{1'b0, 1'b0, 32'h0C, 32'h0, 32'h0BADF00D, 0};
      vt[5] = '{1'b1, 1'b0, 32'h18, 32'h0, 32'h00000077, TMO - 1};
      vt[6] = '{1'b0, 1'b1, 32'h1C, 32'h00000011, 32'h0, TMO};
      vt[7] = '{1'b1, 1'b0, 32'h20, 32'h0, 32'h89ABCDEF, 2};

      repeat (2) @(posedge pclk);
      @(negedge pclk);
      chk("rst_psel", {31'b0, psel}, 32'd0);
      chk("rst_penable", {31'b0, penable}, 32'd0);
      chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_done", {30'b0, done1, done0}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      @(posedge pclk); #1;
      preset = 1;
      mon_on = 1;

      for (int i = 0; i < 8; i++)
         run_vec(vt[i]);

      tie_run(4, 1'b0);

      // Reset in the second ACCESS cycle of a long read.
      @(posedge pclk); #1;
      e.who = 0; e.wr = 0; e.addr = 32'h30; e.wdata = 0;
      e.prd = 32'h0; e.tmo = 0;
      sb.push_back(e);
      slv_waits = 1000;
      req0 = 1; write0 = 0; addr0 = 32'h30;
      pc = 0;
      for (int k = 0; k < 20 && pc < 2; k++) begin
         @(posedge pclk); #1;
         if (penable) pc++;
      end
      chk("rst_mid_reached", 32'(pc), 32'd2);
      preset = 0;
      req1 = 1;
      @(posedge pclk); #1;
      sb.delete();
      m_rdata = 0;
      m_err = 0;
      chk("rstmid_psel", {31'b0, psel}, 32'd0);
      chk("rstmid_penable", {31'b0, penable}, 32'd0);
      chk("rstmid_done", {30'b0, done1, done0}, 32'd0);
      @(posedge pclk); #1;
      chk("rsthold_psel", {31'b0, psel}, 32'd0);
      chk("rsthold_done", {30'b0, done1, done0}, 32'd0);
      req0 = 0;
      req1 = 0;
      preset = 1;
      tie_run(2, 1'b0);

      repeat (3) @(posedge pclk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
